reservation_station: RTL

- Integer reservation station for the out-of-order RISC-V core.
- Accepts issued ALU/branch ops tagged with a ROB label and holds up to RS_SIZE entries.
- Wakes operands by snooping its own CDB and the LSB CDB, then dispatches one ready op per cycle into an internal ALU.
- Drives the RS result bus (tag, value) consumed by the reorder buffer, the LSB and itself.

---
 rtl/reservation_station.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// Integer reservation station: holds issued ALU/branch ops, wakes operands from the
// RS and LSB result buses, and dispatches one ready op per cycle through a local ALU.
module reservation_station #(
    parameter int RS_SIZE      = 8,
    parameter int ROB_ID_WIDTH = 3,
    parameter int VAL_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    issue_en,
    input  logic [3:0]              issue_op,
    input  logic [ROB_ID_WIDTH:0]   issue_tag,
    input  logic [VAL_WIDTH-1:0]    issue_val1,
    input  logic [VAL_WIDTH-1:0]    issue_val2,
    input  logic                    issue_rdy1,
    input  logic                    issue_rdy2,
    input  logic [ROB_ID_WIDTH:0]   issue_lab1,
    input  logic [ROB_ID_WIDTH:0]   issue_lab2,
    input  logic                    lsb_cdb_valid,
    input  logic [ROB_ID_WIDTH:0]   lsb_cdb_lab,
    input  logic [VAL_WIDTH-1:0]    lsb_cdb_val,
    output logic                    rs_full,
    output logic                    cdb_valid,
    output logic [ROB_ID_WIDTH:0]   cdb_lab,
    output logic [VAL_WIDTH-1:0]    cdb_val
);
    localparam int LW = ROB_ID_WIDTH + 1;
    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]   busy, r1, r2;
    logic [3:0]           op   [RS_SIZE];
    logic [LW-1:0]        tag  [RS_SIZE];
    logic [LW-1:0]        l1   [RS_SIZE];
    logic [LW-1:0]        l2   [RS_SIZE];
    logic [VAL_WIDTH-1:0] v1   [RS_SIZE];
    logic [VAL_WIDTH-1:0] v2   [RS_SIZE];

    // Returns {hit, value}; the LSB bus takes priority, label 0 never matches.
    function automatic logic [VAL_WIDTH:0] snoop(
        input logic [LW-1:0] lab,
        input logic lv, input logic [LW-1:0] ll, input logic [VAL_WIDTH-1:0] lval,
        input logic ov, input logic [LW-1:0] ol, input logic [VAL_WIDTH-1:0] oval
    );
        if (lab != '0 && lv && ll == lab) return {1'b1, lval};
        if (lab != '0 && ov && ol == lab) return {1'b1, oval};
        return '0;
    endfunction

    logic [VAL_WIDTH:0] wake1 [RS_SIZE];
    logic [VAL_WIDTH:0] wake2 [RS_SIZE];
    logic [VAL_WIDTH:0] iss1, iss2;
    logic               sel_found, free_found;
    logic [IW-1:0]      sel_idx, free_idx;

    // Issue handshake: issue_en is a valid, !rs_full is the ready; a request is
    // taken only at a rdy_in edge with both high, otherwise it is dropped.
    assign rs_full = &busy;

    always_comb begin
        iss1 = snoop(issue_lab1, lsb_cdb_valid, lsb_cdb_lab, lsb_cdb_val, cdb_valid, cdb_lab, cdb_val);
        iss2 = snoop(issue_lab2, lsb_cdb_valid, lsb_cdb_lab, lsb_cdb_val, cdb_valid, cdb_lab, cdb_val);
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1[i] = snoop(l1[i], lsb_cdb_valid, lsb_cdb_lab, lsb_cdb_val, cdb_valid, cdb_lab, cdb_val);
            wake2[i] = snoop(l2[i], lsb_cdb_valid, lsb_cdb_lab, lsb_cdb_val, cdb_valid, cdb_lab, cdb_val);
        end
        // Scanning downward leaves the lowest matching index as the final pick.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy[i] && r1[i] && r2[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    logic [VAL_WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [4:0]           shamt;
    logic                 lt_s, lt_u, eq;

    always_comb begin
        alu_a = v1[sel_idx];
        alu_b = v2[sel_idx];
        shamt = alu_b[4:0];
        lt_s  = $signed(alu_a) < $signed(alu_b);
        lt_u  = alu_a < alu_b;
        eq    = alu_a == alu_b;
        case (op[sel_idx])
            4'd0:         alu_res = alu_a + alu_b;
            4'd1:         alu_res = alu_a - alu_b;
            4'd2:         alu_res = alu_a & alu_b;
            4'd3:         alu_res = alu_a | alu_b;
            4'd4:         alu_res = alu_a ^ alu_b;
            4'd5:         alu_res = alu_a << shamt;
            4'd6:         alu_res = alu_a >> shamt;
            4'd7:         alu_res = $unsigned($signed(alu_a) >>> shamt);
            4'd8, 4'd12:  alu_res = {{(VAL_WIDTH-1){1'b0}}, lt_s};
            4'd9, 4'd14:  alu_res = {{(VAL_WIDTH-1){1'b0}}, lt_u};
            4'd10:        alu_res = {{(VAL_WIDTH-1){1'b0}}, eq};
            4'd11:        alu_res = {{(VAL_WIDTH-1){1'b0}}, !eq};
            4'd13:        alu_res = {{(VAL_WIDTH-1){1'b0}}, !lt_s};
            default:      alu_res = {{(VAL_WIDTH-1){1'b0}}, !lt_u};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            busy      <= '0;
            cdb_valid <= 1'b0;
            cdb_lab   <= '0;
            cdb_val   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy      <= '0;
                cdb_valid <= 1'b0;
                cdb_lab   <= '0;
                cdb_val   <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && !r1[i] && wake1[i][VAL_WIDTH]) begin
                        r1[i] <= 1'b1;
                        v1[i] <= wake1[i][VAL_WIDTH-1:0];
                    end
                    if (busy[i] && !r2[i] && wake2[i][VAL_WIDTH]) begin
                        r2[i] <= 1'b1;
                        v2[i] <= wake2[i][VAL_WIDTH-1:0];
                    end
                end
                if (sel_found) begin
                    busy[sel_idx] <= 1'b0;
                    cdb_valid     <= 1'b1;
                    cdb_lab       <= tag[sel_idx];
                    cdb_val       <= alu_res;
                end else begin
                    cdb_valid <= 1'b0;
                end
                // The free slot is taken from registered busy bits, so it never
                // collides with the entry being dispatched at this edge.
                if (issue_en && !rs_full && free_found) begin
                    busy[free_idx] <= 1'b1;
                    op[free_idx]   <= issue_op;
                    tag[free_idx]  <= issue_tag;
                    l1[free_idx]   <= issue_lab1;
                    l2[free_idx]   <= issue_lab2;
                    r1[free_idx]   <= issue_rdy1 | iss1[VAL_WIDTH];
                    r2[free_idx]   <= issue_rdy2 | iss2[VAL_WIDTH];
                    v1[free_idx]   <= issue_rdy1 ? issue_val1 : iss1[VAL_WIDTH-1:0];
                    v2[free_idx]   <= issue_rdy2 ? issue_val2 : iss2[VAL_WIDTH-1:0];
                end
            end
        end
    end
endmodule
